// File: rtl/lb_pixel_reader.sv
// lb_pixel_reader
// Read-side engine for the HDMI line buffer. Fetches a run of words from the
// read-only port of the line-buffer memory and unpacks each word into pixels
// on a valid/ready stream (pixel 0 of a word sits in the LSBs).
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle run request, honoured only in IDLE
//   base_addr           first word address of the run
//   word_count          words in the run, 0..2**ADDR_WIDTH
//   abort               cancels the current run, no done pulse
//   busy                high while a run is in progress
//   done                one-cycle pulse after a completed run
//   mem_en/mem_addr     memory read strobe and address
//   mem_we/mem_din      write side of the port, tied off
//   mem_dout            read data, one cycle after mem_en
//   px_valid/px_ready   pixel stream handshake
//   px_data/px_last     pixel and end-of-run marker
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; a zero-length start pulses done directly
// RUN   | issuing reads, buffering words and streaming pixels
// FLUSH | one cycle after abort; late read data and start are ignored
module lb_pixel_reader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_COL      = 4,
  parameter int PIX_WIDTH    = 16,
  parameter int PIX_PER_WORD = 2,
  parameter int DATA_WIDTH   = PIX_WIDTH * PIX_PER_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [PIX_WIDTH-1:0]  px_data,
  output logic                  px_last
);

  localparam int IDX_W = $clog2(PIX_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   issue_left;   // reads still to issue
  logic [ADDR_WIDTH:0]   pop_left;     // words still to hand out
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            buf_cnt;
  logic                  rd_pend;      // read issued last cycle, data on mem_dout now
  logic [IDX_W-1:0]      pix_idx;
  logic                  done_q;

  logic                  rd_issue, push, pop, fire;
  logic [DATA_WIDTH-1:0] head;

  // Buffered words plus the read in flight never exceed the two buffer
  // slots, so the buffer cannot overflow even while the stream stalls.
  always_comb begin
    rd_issue = (state == S_RUN) && ((buf_cnt + 2'(rd_pend)) < 2'd2) &&
               (issue_left != '0);
    push     = (state == S_RUN) && rd_pend;
    head     = buf_q[rd_ptr];
    px_valid = (state == S_RUN) && (buf_cnt != 2'd0);
    px_data  = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (pix_idx == IDX_W'(i)) px_data = head[i*PIX_WIDTH +: PIX_WIDTH];
    end
    px_last  = px_valid && (pix_idx == LAST_IDX) &&
               (pop_left == (ADDR_WIDTH+1)'(1));
    fire     = px_valid && px_ready;
    pop      = fire && (pix_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == S_RUN);
    mem_en    = rd_issue;
    if (abort) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  if (start && (word_count != '0)) state_nxt = S_RUN;
        S_RUN:   if (fire && px_last) state_nxt = S_IDLE;
        S_FLUSH: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
      rd_pend    <= 1'b0;
      pix_idx    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // The read issued this cycle is dropped along with the buffer.
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        buf_cnt <= 2'd0;
        rd_pend <= 1'b0;
        pix_idx <= '0;
      end else begin
        if ((state == S_IDLE) && start) begin
          addr_q     <= base_addr;
          issue_left <= word_count;
          pop_left   <= word_count;
          done_q     <= (word_count == '0);
        end
        rd_pend <= rd_issue;
        if (rd_issue) begin
          addr_q     <= addr_q + ADDR_WIDTH'(1);
          issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
        end
        if (push) begin
          buf_q[wr_ptr] <= mem_dout;
          wr_ptr        <= ~wr_ptr;
        end
        if (fire) pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + IDX_W'(1);
        if (pop) begin
          rd_ptr   <= ~rd_ptr;
          pop_left <= pop_left - (ADDR_WIDTH+1)'(1);
        end
        buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
        if (fire && px_last) done_q <= 1'b1;
      end
    end
  end

  assign done     = done_q;
  assign mem_addr = addr_q;
  assign mem_we   = '0;
  assign mem_din  = '0;

endmodule
